// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide sequencer.
//   muldiv_op_e    : funct3 encodings of the eight M-extension operations
//   muldiv_state_e : sequencer control states
//   IterCount      : iterations per operation (one result bit per cycle)
package muldiv_pkg;

  localparam int unsigned IterCount = 32;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StFix,
    StDone
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic op_a_signed(input muldiv_op_e op);
    return op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
  endfunction

  function automatic logic op_b_signed(input muldiv_op_e op);
    return op inside {OpMulh, OpDiv, OpRem};
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response handshake bundle of the multiply/divide sequencer.
//   in_*  : operation request (valid/ready) with funct3, operands and tag
//   out_* : result response (valid/ready) with result and tag
//   master: pipeline side; slave: sequencer side
interface muldiv_sequencer_if
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  muldiv_op_e       in_funct3;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_funct3, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_funct3, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/muldiv_datapath.sv
// Datapath of the multiply/divide sequencer.
//   load_i : capture operand magnitudes and result sign (or a fast-path result)
//   step_i : one radix-2 shift-add (multiply) or restoring-divide step
//   fix_i  : sign-correct and select the final word into result_o
//   fast_o : combinational; the request on load_op_i/a_i/b_i needs no iteration
// acc_hi/acc_lo hold the product high/low words or the remainder/quotient.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = IterCount
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            fix_i,
  input  muldiv_op_e      load_op_i,
  input  muldiv_op_e      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            fast_o,
  output logic [XLEN-1:0] result_o
);
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  logic [XLEN-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [XLEN-1:0]   b_q, b_d, result_q, result_d;
  logic              neg_q, neg_d;

  logic              a_neg, b_neg, b_zero, ovf;
  logic [XLEN-1:0]   a_mag, b_mag, div_diff, sel;
  logic [XLEN:0]     mul_sum, div_shift;
  logic [2*XLEN-1:0] prod, prod_fix;

  always_comb begin
    a_neg  = op_a_signed(load_op_i) && a_i[XLEN-1];
    b_neg  = op_b_signed(load_op_i) && b_i[XLEN-1];
    a_mag  = a_neg ? -a_i : a_i;
    b_mag  = b_neg ? -b_i : b_i;
    b_zero = op_is_div(load_op_i) && (b_i == '0);
    ovf    = (load_op_i inside {OpDiv, OpRem}) && (a_i == MinInt) && (b_i == '1);
  end

  assign fast_o = b_zero || ovf;

  always_comb begin
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    b_d      = b_q;
    neg_d    = neg_q;
    result_d = result_q;

    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
    // XLEN+1-bit trial remainder; the difference fits XLEN bits whenever it is kept
    div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
    div_diff  = div_shift[XLEN-1:0] - b_q;

    // Negating the full product keeps the high word correct for MULH/MULHSU
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_q ? -prod : prod;

    case (op_i)
      OpMul:                      sel = prod_fix[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu:  sel = prod_fix[2*XLEN-1:XLEN];
      OpDiv, OpDivu:              sel = neg_q ? -acc_lo_q : acc_lo_q;
      default:                    sel = neg_q ? -acc_hi_q : acc_hi_q;
    endcase

    if (load_i) begin
      b_d = b_mag;
      if (b_zero) begin
        acc_hi_d = a_i;
        acc_lo_d = '1;
        neg_d    = 1'b0;
      end else if (ovf) begin
        acc_hi_d = '0;
        acc_lo_d = MinInt;
        neg_d    = 1'b0;
      end else begin
        acc_hi_d = '0;
        acc_lo_d = a_mag;
        // Remainder follows the dividend; everything else follows the operand XOR
        neg_d    = (load_op_i inside {OpRem, OpRemu}) ? a_neg : (a_neg ^ b_neg);
      end
    end else if (step_i) begin
      if (op_is_div(op_i)) begin
        if (div_shift >= {1'b0, b_q}) begin
          acc_hi_d = div_diff;
          acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b1};
        end else begin
          acc_hi_d = div_shift[XLEN-1:0];
          acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        acc_hi_d = mul_sum[XLEN:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[XLEN-1:1]};
      end
    end else if (fix_i) begin
      result_d = sel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle multiply/divide sequencer (EX-stage companion to the ALU).
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : abort any in-flight operation
//   stall      : high whenever not idle; freezes the upstream pipeline
//   bus        : request/response handshakes (muldiv_sequencer_if.slave)
// Flow: IDLE -accept-> ITER (XLEN steps) -> FIX (sign/select) -> DONE -> IDLE.
// Division by zero and signed overflow skip ITER.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = IterCount,
  parameter int unsigned TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  output logic              stall,
  muldiv_sequencer_if.slave bus
);
  localparam int unsigned CntW = $clog2(XLEN);

  muldiv_state_e    state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  muldiv_op_e       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             load, step, fix, fast;
  logic [XLEN-1:0]  result;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpMul;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.in_valid && !flush) state_d = fast ? StFix : StIter;
      StIter: begin
        if (flush)              state_d = StIdle;
        else if (cnt_q == '0)   state_d = StFix;
      end
      StFix:  state_d = flush ? StIdle : StDone;
      StDone: if (flush || bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    stall         = (state_q != StIdle);
    load          = (state_q == StIdle) && bus.in_valid && !flush;
    step          = (state_q == StIter) && !flush;
    fix           = (state_q == StFix) && !flush;
  end

  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    tag_d = tag_q;
    if (load) begin
      cnt_d = CntW'(XLEN - 1);
      op_d  = bus.in_funct3;
      tag_d = bus.in_tag;
    end else if (step) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  muldiv_datapath #(
    .XLEN(XLEN)
  ) u_datapath (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .load_i   (load),
    .step_i   (step),
    .fix_i    (fix),
    .load_op_i(bus.in_funct3),
    .op_i     (op_q),
    .a_i      (bus.in_a),
    .b_i      (bus.in_b),
    .fast_o   (fast),
    .result_o (result)
  );

  assign bus.out_result = result;
  assign bus.out_tag    = tag_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: the driver pushes model results on accept,
// the monitor pops and compares whenever out_valid is presented.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;

  logic clk = 1'b0;
  logic rst_n, flush, stall;

  muldiv_sequencer_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  muldiv_sequencer #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .stall(stall),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          t_acc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   seen = 0;
  int   hs_cyc = 0;
  int   ready_mode = 1;  // 0 hold low, 1 hold high, 2 random

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model straight from the RV32M definitions
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    bit ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
    case (f3)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hffff_ffff;
        if (ovf)    return 32'h8000_0000;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hffff_ffff : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    bit sgn;
    sgn = (f3 == 3'd4) || (f3 == 3'd6);
    if (f3[2] && ((b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hffff_ffff))) return 2;
    return XLEN + 2;
  endfunction

  // Caller is at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input bit push, output int t_acc);
    exp_t e;
    bus.in_valid  = 1'b1;
    bus.in_funct3 = muldiv_op_e'(f3);
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_tag    = tag;
    for (int i = 0; i < 200 && !bus.in_ready; i++) @(negedge clk);
    check("accept_wait", bus.in_ready, 1);
    t_acc = cyc + 1;
    if (push) begin
      e.res   = model(f3, a, b);
      e.tag   = tag;
      e.t_acc = t_acc;
      e.lat   = latency(f3, a, b);
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max && !bus.out_valid; i++) @(negedge clk);
    check("wait_valid", bus.out_valid, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (exp_q.size() != 0 || !bus.in_ready); i++) @(negedge clk);
    check("drain", (exp_q.size() == 0) && bus.in_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tagname);
    check({tagname, "_in_ready"}, bus.in_ready, 1);
    check({tagname, "_out_valid"}, bus.out_valid, 0);
    check({tagname, "_stall"}, stall, 0);
    check({tagname, "_out_result"}, bus.out_result, 0);
    check({tagname, "_out_tag"}, bus.out_tag, 0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hffff_ffff;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  // Sole driver of out_ready, updated just after each rising edge
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!bus.out_valid) begin
      seen = 0;
    end else if (!seen) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        cur = exp_q.pop_front();
        check("result", bus.out_result, cur.res);
        check("tag", bus.out_tag, cur.tag);
        check("latency", cyc + 1 - cur.t_acc, cur.lat);
        check("done_in_ready", bus.in_ready, 0);
        check("done_stall", stall, 1);
      end
      seen = 1;
    end else begin
      check("hold_result", bus.out_result, cur.res);
      check("hold_tag", bus.out_tag, cur.tag);
      check("hold_in_ready", bus.in_ready, 0);
    end
    if (bus.out_valid && bus.out_ready) begin
      seen   = 0;
      hs_cyc = cyc + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_funct3 = OpMul;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operations
    issue(3'd0, 32'd7, 32'hffff_fffd, 5'd1, 1, t);
    check("stall_after_accept", stall, 1);
    issue(3'd3, 32'hffff_ffff, 32'hffff_ffff, 5'd2, 1, t);
    issue(3'd2, 32'hffff_ffff, 32'd2, 5'd3, 1, t);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 1, t);
    issue(3'd4, 32'hffff_fff9, 32'd2, 5'd5, 1, t);
    issue(3'd6, 32'hffff_fff9, 32'd2, 5'd6, 1, t);
    issue(3'd5, 32'd5, 32'd0, 5'd7, 1, t);
    issue(3'd6, 32'd5, 32'd0, 5'd8, 1, t);
    issue(3'd4, 32'h8000_0000, 32'hffff_ffff, 5'd9, 1, t);
    issue(3'd7, 32'd100, 32'd7, 5'd10, 1, t);
    drain();

    // Backpressure in DONE, then back-to-back accept after the handshake
    ready_mode = 0;
    @(negedge clk);
    issue(3'd0, 32'h1234_5678, 32'h0000_0010, 5'd11, 1, t);
    wait_valid(60);
    repeat (10) @(negedge clk);
    ready_mode = 1;
    @(negedge clk);
    @(negedge clk);
    check("post_hs_in_ready", bus.in_ready, 1);
    check("post_hs_out_valid", bus.out_valid, 0);
    issue(3'd5, 32'd1000, 32'd3, 5'd12, 1, t);
    check("next_accept_delay", t - hs_cyc, 1);
    check("next_accept_stall", stall, 1);
    drain();

    // Flush at T+10 of a DIV: idle next cycle, no result ever
    issue(3'd4, 32'hdead_beef, 32'd3, 5'd13, 0, t);
    while (cyc < t + 9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_in_ready", bus.in_ready, 1);
    check("flush_stall", stall, 0);
    check("flush_out_valid", bus.out_valid, 0);
    repeat (40) @(negedge clk);

    // Flush in IDLE blocks the accept
    flush         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_funct3 = OpMul;
    @(negedge clk);
    check("idle_flush_no_accept", stall, 0);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    repeat (40) @(negedge clk);

    // Reset (with flush) at T+5 of a MUL
    issue(3'd0, 32'h0000_abcd, 32'h0001_0001, 5'd14, 0, t);
    while (cyc < t + 4) @(negedge clk);
    rst_n = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    flush = 1'b0;
    repeat (40) @(negedge clk);

    // Random operations under random backpressure
    ready_mode = 2;
    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
            5'($urandom_range(0, 31)), 1, t);
    end
    ready_mode = 1;
    @(negedge clk);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the RV32M extension: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits beside the main ALU in the EX stage. It accepts one operation through a valid/ready handshake and holds the pipeline via `stall` while it iterates.
- Iteration is a radix-2 shift-add for multiplies and restoring division for divides, both on operand magnitudes, followed by one sign-fix cycle.
- The result returns with its destination tag through a valid/ready handshake.

Parameters:
- XLEN, 32, operand and result width.
- TAG_W, 5, width of the destination-register tag carried with the operation.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  sequencer can accept an operation (state IDLE).
- in_funct3  in  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_a  in  XLEN  rs1 operand.
- in_b  in  XLEN  rs2 operand.
- in_tag  in  TAG_W  destination tag.
- flush  in  1  abort any in-flight operation (branch/JAL redirect).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  tag of the result.
- stall  out  1  asserted whenever state is not IDLE; freezes the upstream pipeline.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, stall=0, out_result=0, out_tag=0.
  - Internal accumulators and counter are cleared.
  - Reset mid-operation discards the operation; no result is produced.
- States: IDLE, ITER, FIX, DONE.
- Accept:
  - in_valid && in_ready at edge T: latch funct3 and tag.
  - Latch the magnitudes of a and b. Signedness: MULH a,b signed; MULHSU a signed, b unsigned; DIV/REM signed; all others unsigned.
  - Latch the result sign.
  - Load counter = XLEN-1 and go to ITER.
- Division fast paths, decided at accept; go directly to FIX and skip ITER:
  - b==0: quotient = all ones; remainder = a, unmodified.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- ITER:
  - One bit per cycle for exactly XLEN cycles; the counter decrements each cycle.
  - Leave to FIX when counter==0.
  - Multiply keeps a 2*XLEN product.
  - Divide keeps an XLEN quotient and an XLEN+1 partial remainder.
- FIX (1 cycle):
  - Apply two's-complement negation where the sign requires. Remainder takes the dividend's sign.
  - Select low/high product word, quotient or remainder into out_result.
  - Go to DONE.
- DONE:
  - out_valid=1; out_result and out_tag are held stable until out_ready=1.
  - On handshake, go to IDLE at that edge.
  - in_ready stays 0 in DONE, so there is no same-cycle accept of the next operation.
- Latency:
  - Normal op accepted at T: out_valid first high at T+XLEN+2 (T+34 for XLEN=32).
  - Fast path: out_valid at T+2.
- stall is the same as (state != IDLE), so it is high from T+1 through the DONE handshake edge.
- flush:
  - In any non-IDLE state, flush at an edge returns the state to IDLE and deasserts out_valid next cycle.
  - Flush has priority over the out_ready handshake and over accept.
  - Flush in IDLE with in_valid=1: the request is not accepted.
- Simultaneous rst_n=0 and flush: reset wins; the outcome is identical.
- Unused/illegal combinations do not exist: all 8 funct3 codes are valid.

Decomposition:
- Shared package muldiv_pkg holds:
  - enum muldiv_op_e for the 8 funct3 codes;
  - enum muldiv_state_e {IDLE, ITER, FIX, DONE};
  - localparam for the iteration count.
- One sub-module, muldiv_datapath:
  - holds the accumulator/remainder registers and the per-cycle shift-add / subtract-restore step;
  - is driven by load/step/fix strobes from the FSM in muldiv_sequencer.

Test Plan:
- MUL a=7, b=0xFFFFFFFD accepted at T → out_valid at T+34, out_result=0xFFFFFFEB; stall high T+1..handshake.
- MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF; both at T+34.
- DIVU a=5, b=0 → 0xFFFFFFFF at T+2; REM a=5, b=0 → 5; DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000 at T+2.
- Backpressure: out_ready held 0 for 10 cycles in DONE → result/tag stable, in_ready=0. Then out_ready=1 → IDLE next cycle, and a new op is accepted the following cycle.
- flush asserted at T+10 of a DIV → state IDLE at T+11, out_valid never rises. rst_n=0 at T+5 of a MUL → all outputs at reset values next cycle.
